// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: widths, PC step, reset vector, fetch FSM states
// and the buffered-instruction entry type.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP           = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VEC = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer holding {instruction, pc} pairs; flush wins
// over push and pop, and a full buffer still accepts a push when it also pops.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: single-outstanding memory requests into a small
// buffer feeding the decoder. Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects.
//
// state | meaning
// IDLE  | first cycle out of reset, no request yet
// REQ   | request pc while the buffer has room, hold address until grant
// WAIT  | one request outstanding, next rvalid is pushed into the buffer
// DROP  | one request outstanding but stale after a redirect, next rvalid discarded
// HALT  | misaligned redirect seen, fetch stopped until an aligned redirect
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_VEC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_value,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_pc;
    logic             outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic [XLEN-1:0]  target;
    logic             bad_target;
    logic             take_gnt;
    logic             fifo_push;
    logic             fifo_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target     = redirect_pc;
    assign bad_target = is_misaligned(redirect_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            misalign_err <= bad_target;
        end
    end
`else
    assign target       = redirect_pc & ~32'h0000_0003;
    assign bad_target   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Outstanding is zero in REQ by construction; it is counted anyway so the
    // room check reads as buffer slots already spoken for.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(outstanding);
    assign imem_req  = (state == REQ) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem_addr = pc;
    assign take_gnt  = imem_req && imem_gnt;

    assign fifo_push  = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign fifo_pop   = inst_valid && inst_ready;
    assign push_entry = '{inst: imem_rdata, pc: req_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
        end else begin
            if (take_gnt) begin
                outstanding <= 1'b1;
                req_pc      <= pc;
            end else if (imem_rvalid) begin
                outstanding <= 1'b0;
            end

            if (redirect_valid) begin
                pc <= target;
                // A response still owed to the old stream must be swallowed by DROP.
                if (bad_target) begin
                    state <= HALT;
                end else if (take_gnt || (outstanding && !imem_rvalid)) begin
                    state <= DROP;
                end else begin
                    state <= REQ;
                end
            end else begin
                case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        if (take_gnt) begin
                            pc    <= pc_advance(pc);
                            state <= WAIT;
                        end
                    end
                    WAIT: if (imem_rvalid) state <= REQ;
                    DROP: if (imem_rvalid) state <= REQ;
                    HALT: state <= HALT;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign inst_valid = (fifo_count != '0);
    assign inst_value = fifo_head.inst;
    assign inst_pc    = fifo_head.pc;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, instruction buffer entries (legal 2..4).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  instruction-memory request.
REQ-006 SHALL have port imem_addr  output  32  request word address.
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port inst_valid  output  1  buffered instruction available to the decoder.
REQ-013 SHALL have port inst_ready  input  1  decoder accepts instruction.
REQ-014 SHALL have port inst_value  output  32  instruction word (decoder op_value).
REQ-015 SHALL have port inst_pc  output  32  address of inst_value.
REQ-016 SHALL have port misalign_err  output  1  misaligned-redirect flag.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT, DROP, HALT.
REQ-018 IDLE SHALL move to REQ on the first clock edge after rst_n deasserts.
REQ-019 In REQ, imem_req SHALL be 1 only while fifo_count + outstanding < FIFO_DEPTH; imem_addr = pc; address held stable until imem_gnt.
REQ-020 On imem_gnt in REQ: pc <= pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), state -> WAIT.
REQ-021 At most one request SHALL be outstanding; WAIT deasserts imem_req.
REQ-022 In WAIT, imem_rvalid SHALL push {imem_rdata, request pc} into the FIFO and return to REQ.
REQ-023 inst_valid = FIFO non-empty; inst_value/inst_pc = FIFO head; pop on inst_valid && inst_ready.
REQ-024 Push and pop in the same cycle SHALL both occur; count unchanged.
REQ-025 inst_value/inst_pc SHALL be held stable while inst_valid && !inst_ready.
REQ-026 redirect_valid SHALL have top priority: FIFO flushed same cycle, pc <= redirect_pc, inst_valid 0 next cycle.
REQ-027 Redirect while WAIT, or in REQ coincident with imem_gnt, SHALL go to DROP; DROP discards the next imem_rvalid, then -> REQ.
REQ-028 Redirect with no outstanding request SHALL go to REQ; imem_req with new address asserted the following cycle.
REQ-029 Redirect coincident with imem_rvalid SHALL discard that data.
REQ-030 Redirect-to-first-decoder-valid latency SHALL be 3 cycles with zero-wait memory (gnt same cycle, rvalid next cycle).

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, pc = RESET_PC, FIFO empty, outstanding 0, imem_req 0, imem_addr = RESET_PC, inst_valid 0, inst_value 0, inst_pc 0, misalign_err 0.
REQ-032 Reset during WAIT SHALL discard any later imem_rvalid until the first post-reset grant.

Configuration
REQ-033 With FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0] != 0 SHALL flush, set misalign_err=1 (sticky) and enter HALT (no requests, pending response dropped) until an aligned redirect clears it.
REQ-034 Without FETCH_MISALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 0, misalign_err tied 0, HALT unreachable.

Structure
REQ-035 Shared package riscv_pkg SHALL hold XLEN=32, ILEN=32, fetch-state enum, PC_STEP=4, default reset vector.
REQ-036 FIFO SHALL be sub-module fetch_fifo (parameterised depth, push/pop/flush, count output).

Verification
REQ-037 Reset release, zero-wait memory returning 32'h0000_0013 at 0,4,8, inst_ready=1 -> inst_pc 0,4,8 on consecutive valid cycles.
REQ-038 inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered, imem_req 0, head stable at pc 0.
REQ-039 Redirect to 32'h0000_0100 during WAIT, stale rdata 32'hDEAD_BEEF returned -> dropped; next inst_pc 32'h100.
REQ-040 Redirect coincident with imem_rvalid and a pop -> FIFO empty next cycle, no stale instruction delivered.
REQ-041 pc=32'hFFFF_FFFC fetched -> next imem_addr 32'h0000_0000.
REQ-042 With FETCH_MISALIGN_CHECK_EN, redirect to 32'h0000_0102 -> misalign_err 1, no imem_req; redirect to 32'h200 -> err clears, fetch resumes at 32'h200.
